// File: rtl/dcache_pkg.sv
// Shared types and helpers for the parametrised write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB      = 2'd1,
    FILL    = 2'd2,
    INSTALL = 2'd3
  } state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  function automatic int unsigned off_w(int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(int unsigned sets, int unsigned line_words);
    return ADDR_W - off_w(line_words) - idx_w(sets) - 2;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One way of the cache: tag/valid/dirty/data storage with index read,
// word write and full-line install with optional word merge.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8,
  localparam int unsigned OFF_W     = off_w(LINE_WORDS),
  localparam int unsigned IDX_W     = idx_w(SETS),
  localparam int unsigned TAG_W     = tag_w(SETS, LINE_WORDS),
  localparam int unsigned LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic              word_we,
  input  logic [OFF_W-1:0]  word_sel,
  input  logic [31:0]       word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              line_dirty,
  input  logic              merge_en,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0] fill_line;

  // Incoming line with the pending CPU store folded in
  always_comb begin
    fill_line = line_data;
    if (merge_en) fill_line[{word_sel, 5'b0} +: WORD_W] = word_data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= line_dirty;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= fill_line;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'b0} +: WORD_W] <= word_data;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate data cache (1 or 2 ways, LRU) with miss FSM,
// dirty-victim write-back and addressed line-fill handshakes.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned LINE_W     = 32 * LINE_WORDS
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              RW,
  input  logic [31:0]       WData,
  input  logic [31:0]       Address,
  output logic [31:0]       RData,
  output logic              Stall,
  output logic              LW_Enable,
  input  logic              LW_Completed,
  output logic [LINE_W-1:0] LW_LineData,
  output logic [31:0]       LW_LineAddr,
  output logic              LB_Enable,
  output logic [31:0]       LB_Addr,
  input  logic              LB_Completed,
  input  logic [LINE_W-1:0] LB_LineData,
  output logic [31:0]       HitCount,
  output logic [31:0]       MissCount
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int unsigned LO_W  = OFF_W + 2;

  state_t                     state;
  logic [ADDR_W-1:LO_W]       cap_line;
  logic [OFF_W-1:0]           cap_word;
  logic [31:0]                cap_wdata;
  logic                       cap_rw;
  logic                       vict_q;
  logic                       retry_q;
  logic [LINE_W-1:0]          fill_q;

  logic [OFF_W-1:0]  cur_word;
  logic [IDX_W-1:0]  cur_idx, cap_idx, idx;
  logic [TAG_W-1:0]  cur_tag, cap_tag;
  logic              lookup, hit, hit_c, miss_c, lru_c, addr_lo_unused;

  assign cur_word = Address[LO_W-1:2];
  assign cur_idx  = Address[LO_W+IDX_W-1:LO_W];
  assign cur_tag  = Address[ADDR_W-1:LO_W+IDX_W];
  assign cap_idx  = cap_line[LO_W+IDX_W-1:LO_W];
  assign cap_tag  = cap_line[ADDR_W-1:LO_W+IDX_W];
  assign addr_lo_unused = ^Address[1:0];

  // Arrays look up the CPU address in IDLE, otherwise the captured miss
  assign lookup = (state == IDLE);
  assign idx    = lookup ? cur_idx : cap_idx;

  logic              way_valid [WAYS];
  logic              way_dirty [WAYS];
  logic [TAG_W-1:0]  way_tag   [WAYS];
  logic [LINE_W-1:0] way_line  [WAYS];
  logic [WAYS-1:0]   way_hit, word_we, line_we;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = way_valid[w] && (way_tag[w] == cur_tag);
    assign word_we[w] = hit_c && RW && way_hit[w];
    assign line_we[w] = (state == INSTALL) && (vict_q == 1'(w));

    dcache_way_array #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .Clk        (Clk),
      .Rst        (Rst),
      .idx        (idx),
      .word_we    (word_we[w]),
      .word_sel   (lookup ? cur_word : cap_word),
      .word_data  (lookup ? WData : cap_wdata),
      .line_we    (line_we[w]),
      .line_tag   (cap_tag),
      .line_data  (fill_q),
      .line_dirty (cap_rw),
      .merge_en   (cap_rw),
      .valid      (way_valid[w]),
      .dirty      (way_dirty[w]),
      .tag        (way_tag[w]),
      .line       (way_line[w])
    );
  end

  assign hit    = |way_hit;
  assign hit_c  = lookup && En && hit;
  assign miss_c = lookup && En && !hit;

  logic              hit_way, vict_c, vict_sel, vict_valid, vict_dirty;
  logic [TAG_W-1:0]  vict_tag;
  logic [LINE_W-1:0] hit_line, vict_line;

  // Hit way mux and victim choice: first invalid way, else LRU
  always_comb begin
    hit_way    = 1'b0;
    hit_line   = '0;
    vict_c     = 1'b0;
    vict_valid = 1'b0;
    vict_dirty = 1'b0;
    vict_tag   = '0;
    vict_line  = '0;
    if (WAYS > 1 && way_valid[0]) vict_c = way_valid[WAYS-1] ? lru_c : 1'b1;
    vict_sel = lookup ? vict_c : vict_q;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        hit_line = way_line[w];
      end
      if (vict_sel == 1'(w)) begin
        vict_valid = way_valid[w];
        vict_dirty = way_dirty[w];
        vict_tag   = way_tag[w];
        vict_line  = way_line[w];
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;  // 1 = way 1 is least recently used
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)                    lru_q <= '0;
      else if (hit_c)             lru_q[idx] <= ~hit_way;
      else if (state == INSTALL)  lru_q[idx] <= ~vict_q;
    end
    assign lru_c = lru_q[idx];
  end else begin : g_no_lru
    assign lru_c = 1'b0;
  end

  assign RData       = hit_c ? hit_line[{cur_word, 5'b0} +: WORD_W] : 32'd0;
  assign Stall       = !Rst && (!lookup || miss_c);
  assign LW_Enable   = (state == WB);
  assign LB_Enable   = (state == FILL);
  assign LW_LineData = vict_line;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      cap_line    <= '0;
      cap_word    <= '0;
      cap_wdata   <= '0;
      cap_rw      <= 1'b0;
      vict_q      <= 1'b0;
      retry_q     <= 1'b0;
      fill_q      <= '0;
      LW_LineAddr <= '0;
      LB_Addr     <= '0;
      HitCount    <= '0;
      MissCount   <= '0;
    end else begin
      case (state)
        IDLE: if (En) begin
          retry_q <= 1'b0;
          if (hit) begin
            if (!retry_q) HitCount <= sat_inc(HitCount);
          end else begin
            cap_line    <= Address[ADDR_W-1:LO_W];
            cap_word    <= cur_word;
            cap_wdata   <= WData;
            cap_rw      <= RW;
            vict_q      <= vict_c;
            MissCount   <= sat_inc(MissCount);
            LW_LineAddr <= {vict_tag, cur_idx, {LO_W{1'b0}}};
            LB_Addr     <= {Address[ADDR_W-1:LO_W], {LO_W{1'b0}}};
            state       <= (vict_valid && vict_dirty) ? WB : FILL;
          end
        end
        WB: if (LW_Completed) state <= FILL;
        FILL: if (LB_Completed) begin
          fill_q <= LB_LineData;
          state  <= INSTALL;
        end
        INSTALL: begin
          retry_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed self-checking bench: the cache+memory pair is modelled as flat
// memory, the cache itself as per-set recency lists of line addresses.
`timescale 1ns/1ps
module tb_dcache_assoc;

  localparam int unsigned LINE_W = 256;

  logic              Clk = 1'b0;
  logic              Rst, En, RW, LW_Completed, LB_Completed;
  logic [31:0]       WData, Address, RData, LW_LineAddr, LB_Addr, HitCount, MissCount;
  logic              Stall, LW_Enable, LB_Enable;
  logic [LINE_W-1:0] LW_LineData, LB_LineData;

  always #5 Clk = ~Clk;

  dcache_assoc #(.WAYS(2), .SETS(64), .LINE_WORDS(8)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .WData(WData), .Address(Address),
    .RData(RData), .Stall(Stall), .LW_Enable(LW_Enable), .LW_Completed(LW_Completed),
    .LW_LineData(LW_LineData), .LW_LineAddr(LW_LineAddr), .LB_Enable(LB_Enable),
    .LB_Addr(LB_Addr), .LB_Completed(LB_Completed), .LB_LineData(LB_LineData),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model
  logic [31:0] bmem [int unsigned];      // backing memory seen by the handshakes
  logic [31:0] flat [int unsigned];      // architectural memory seen by the CPU
  logic [31:0] lines_q [64][$];          // cached line addresses per set, MRU first
  bit          line_dirty [int unsigned];
  logic [31:0] exp_hits, exp_misses;

  // Word k of line 0x40 holds 0x1000 + 4k; other lines get distinct upper bits
  function automatic logic [31:0] pattern(logic [31:0] a);
    return 32'h1000 + (a & 32'h1C) + (((a >> 5) ^ 32'd2) << 16);
  endfunction

  function automatic logic [31:0] bread(logic [31:0] a);
    return bmem.exists(a & ~32'd3) ? bmem[a & ~32'd3] : pattern(a & ~32'd3);
  endfunction

  function automatic logic [31:0] fread(logic [31:0] a);
    return flat.exists(a & ~32'd3) ? flat[a & ~32'd3] : pattern(a & ~32'd3);
  endfunction

  function automatic logic [LINE_W-1:0] bline(logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = bread(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] fline(logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = fread(la + 32'(4*k));
    return l;
  endfunction

  // Per-cycle expectations driven alongside the stimulus
  bit                chk_on = 1'b0;
  logic              exp_stall = 1'b0, exp_lw = 1'b0, exp_lb = 1'b0, exp_rd_v = 1'b0;
  logic [31:0]       exp_rdata = '0, exp_lw_addr = '0, exp_lb_addr = '0;
  logic [LINE_W-1:0] exp_lw_data = '0;

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("stall", 32'(Stall), 32'(exp_stall));
      chk("lw_enable", 32'(LW_Enable), 32'(exp_lw));
      chk("lb_enable", 32'(LB_Enable), 32'(exp_lb));
      chk("hit_count", HitCount, exp_hits);
      chk("miss_count", MissCount, exp_misses);
      if (exp_rd_v) chk("rdata", RData, exp_rdata);
      if (exp_lw) begin
        chk("lw_line_addr", LW_LineAddr, exp_lw_addr);
        chk_line("lw_line_data", LW_LineData, exp_lw_data);
      end
      if (exp_lb) chk("lb_addr", LB_Addr, exp_lb_addr);
    end
  end

  int                obs_stall_n;
  logic [31:0]       obs_rdata, obs_lw_addr, obs_lb_addr;
  logic [LINE_W-1:0] obs_lw_data;

  task automatic cyc();
    @(negedge Clk);
    if (Stall) obs_stall_n++;
    if (LW_Enable) begin
      obs_lw_addr = LW_LineAddr;
      obs_lw_data = LW_LineData;
    end
    if (LB_Enable) obs_lb_addr = LB_Addr;
    obs_rdata = RData;
    @(posedge Clk);
    #1;
  endtask

  // One CPU access served to completion, acting as the memory side as well
  task automatic access(logic [31:0] addr, logic rw, logic [31:0] wd,
                        int wb_wait, int fill_wait, bit glitch);
    logic [31:0] la, victim;
    int          s, pos;
    bit          evict_dirty;
    la = addr & ~32'h1F;
    s  = int'((addr >> 5) & 32'd63);
    pos = -1;
    victim = '0;
    evict_dirty = 1'b0;
    for (int i = 0; i < lines_q[s].size(); i++) if (lines_q[s][i] == la) pos = i;
    obs_stall_n = 0; obs_lw_addr = '0; obs_lb_addr = '0; obs_lw_data = '0;
    En = 1'b1; RW = rw; WData = wd; Address = addr;
    exp_lw = 1'b0; exp_lb = 1'b0;
    if (pos >= 0) begin
      exp_stall = 1'b0; exp_rd_v = 1'b1; exp_rdata = fread(addr);
      lines_q[s].delete(pos);
      lines_q[s].push_front(la);
      cyc();
      if (rw) begin
        flat[addr & ~32'd3] = wd;
        line_dirty[la] = 1'b1;
      end
      if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
    end else begin
      exp_stall = 1'b1; exp_rd_v = 1'b0;
      if (lines_q[s].size() == 2) begin
        victim = lines_q[s].pop_back();
        evict_dirty = line_dirty[victim];
        line_dirty.delete(victim);
      end
      cyc();
      if (exp_misses != 32'hFFFF_FFFF) exp_misses++;
      if (evict_dirty) begin
        exp_lw = 1'b1; exp_lw_addr = victim; exp_lw_data = fline(victim);
        for (int i = 0; i < wb_wait; i++) begin
          LB_Completed = glitch && (i == 2);
          LB_LineData  = glitch ? '1 : '0;
          cyc();
        end
        LB_Completed = 1'b0;
        LW_Completed = 1'b1;
        cyc();
        LW_Completed = 1'b0;
        exp_lw = 1'b0;
        for (int k = 0; k < 8; k++) bmem[victim + 32'(4*k)] = fread(victim + 32'(4*k));
      end
      exp_lb = 1'b1; exp_lb_addr = la;
      for (int i = 0; i < fill_wait; i++) begin
        LW_Completed = glitch && (i == 1);
        cyc();
      end
      LW_Completed = 1'b0;
      LB_Completed = 1'b1;
      LB_LineData  = bline(la);
      cyc();
      LB_Completed = 1'b0;
      exp_lb = 1'b0;
      lines_q[s].push_front(la);
      line_dirty[la] = rw;
      if (rw) flat[addr & ~32'd3] = wd;
      cyc();
      exp_stall = 1'b0; exp_rd_v = 1'b1; exp_rdata = fread(addr);
      cyc();
    end
    En = 1'b0; exp_rd_v = 1'b0; exp_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; En = 1'b0; RW = 1'b0; WData = '0; Address = '0;
    LW_Completed = 1'b0; LB_Completed = 1'b0; LB_LineData = '0;
    exp_hits = '0; exp_misses = '0;
    #12;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_lw_enable", 32'(LW_Enable), 32'd0);
    chk("rst_lb_enable", 32'(LB_Enable), 32'd0);
    chk("rst_rdata", RData, 32'd0);
    chk("rst_lw_addr", LW_LineAddr, 32'd0);
    chk("rst_lb_addr", LB_Addr, 32'd0);
    chk("rst_hits", HitCount, 32'd0);
    chk("rst_misses", MissCount, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk_on = 1'b1;
    cyc();

    // Cold read miss, clean fill
    access(32'h0000_0044, 1'b0, '0, 0, 0, 1'b0);
    chk("s1_stall_cycles", obs_stall_n, 32'd3);
    chk("s1_lb_addr", obs_lb_addr, 32'h0000_0040);
    chk("s1_rdata", obs_rdata, 32'h0000_1004);
    chk("s1_misses", MissCount, 32'd1);
    chk("s1_hits", HitCount, 32'd0);

    // Write hit then read hit
    access(32'h0000_0048, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
    chk("s2_write_stall", obs_stall_n, 32'd0);
    access(32'h0000_0048, 1'b0, '0, 0, 0, 1'b0);
    chk("s2_read_stall", obs_stall_n, 32'd0);
    chk("s2_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("s2_hits", HitCount, 32'd2);

    // Fill way 1, then evict dirty LRU way 0
    access(32'h0000_0840, 1'b0, '0, 0, 0, 1'b0);
    access(32'h0000_1040, 1'b0, '0, 0, 0, 1'b0);
    chk("s3_stall_cycles", obs_stall_n, 32'd4);
    chk("s3_lw_addr", obs_lw_addr, 32'h0000_0040);
    chk("s3_lw_word2", obs_lw_data[95:64], 32'hDEAD_BEEF);
    chk("s3_lb_addr", obs_lb_addr, 32'h0000_1040);

    // Write miss merges the store into the filled line
    access(32'h0000_2004, 1'b1, 32'hCAFE_0001, 0, 0, 1'b0);
    chk("s4_rdata", obs_rdata, 32'hCAFE_0001);
    access(32'h0000_2000, 1'b0, '0, 0, 0, 1'b0);
    chk("s4_word0", obs_rdata, 32'h0102_1000);

    // Slow write-back with stray completions on the wrong handshake
    access(32'h0000_0800, 1'b0, '0, 0, 0, 1'b0);
    access(32'h0000_1000, 1'b0, '0, 10, 3, 1'b1);
    chk("s5_stall_cycles", obs_stall_n, 32'd17);
    chk("s5_lw_addr", obs_lw_addr, 32'h0000_2000);
    chk("s5_lw_word1", obs_lw_data[63:32], 32'hCAFE_0001);
    chk("s5_lw_word0", obs_lw_data[31:0], 32'h0102_1000);
    chk("s5_lb_addr", obs_lb_addr, 32'h0000_1000);

    // Asynchronous reset in the middle of a fill
    En = 1'b1; RW = 1'b0; Address = 32'h0000_4080;
    exp_stall = 1'b1;
    cyc();
    exp_misses++;
    exp_lb = 1'b1; exp_lb_addr = 32'h0000_4080;
    cyc();
    chk("s6_in_fill", 32'(LB_Enable), 32'd1);
    chk_on = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk("s6_lb_enable_async", 32'(LB_Enable), 32'd0);
    chk("s6_stall_async", 32'(Stall), 32'd0);
    chk("s6_hits_async", HitCount, 32'd0);
    chk("s6_misses_async", MissCount, 32'd0);
    En = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < 64; i++) lines_q[i].delete();
    line_dirty.delete();
    flat = bmem;
    exp_hits = '0; exp_misses = '0;
    exp_lb = 1'b0; exp_stall = 1'b0;
    chk_on = 1'b1;
    cyc();
    access(32'h0000_1044, 1'b0, '0, 0, 0, 1'b0);
    chk("s6_stall_cycles", obs_stall_n, 32'd3);
    chk("s6_rdata", obs_rdata, 32'h0080_1004);
    chk("s6_misses", MissCount, 32'd1);
    chk("s6_hits", HitCount, 32'd0);

    cyc();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
